mont_seq_ctrl: RTL and testbench

Control sequencer for the carry-save multi-precision adder `mpadder`. It is the initiator to the adder's responder. It runs the bit-serial Montgomery loop: per bit of B, it adds A, conditionally adds M, then shifts. It then collapses the carry-save pair in five 103-bit chunk passes and repeats subtract-M passes until the adder reports completion. It sits between the top-level command interface and `mpadder`, and owns every adder control line.

---
 rtl/mont_seq_ctrl_pkg.sv | 32 +++
 rtl/mont_phase_cnt.sv | 35 +++
 rtl/mont_seq_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mont_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_seq_ctrl_pkg.sv
// ============================================================================
//  Module   : mont_seq_ctrl_pkg
//  Purpose  : Shared state encoding, adder select codes and sizing defaults
//             for the Montgomery sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mont_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_INIT  = 3'd1,
      S_ADD_B = 3'd2,
      S_ADD_M = 3'd3,
      S_SHIFT = 3'd4,
      S_RES   = 3'd5,
      S_SUB   = 3'd6,
      S_DONE  = 3'd7
   } state_t;

   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_A    = 2'd1;
   localparam logic [1:0] SEL_M    = 2'd2;
   localparam logic [1:0] SEL_NEGM = 2'd3;

   localparam int CHUNK_LAST = 4;
   localparam int N_BITS_DEF = 512;

endpackage

`default_nettype wire

// File: rtl/mont_phase_cnt.sv
// ============================================================================
//  Module   : mont_phase_cnt
//  Purpose  : Chunk phase counter 0..N_CHUNKS-1 with wrap and last flag,
//             shared by the resolve and subtract passes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_phase_cnt #(
   parameter int N_CHUNKS = 5,
   parameter int PHASE_W  = 4
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               en,
   output logic [PHASE_W-1:0] phase,
   output logic               last
);

   assign last = (phase == PHASE_W'(N_CHUNKS - 1));

   // Held at zero whenever no chunk pass is running.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         phase <= '0;
      end else if (!en || last) begin
         phase <= '0;
      end else begin
         phase <= phase + PHASE_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/mont_seq_ctrl.sv
// ============================================================================
//  Module   : mont_seq_ctrl
//  Purpose  : Bit-serial Montgomery loop sequencer driving the carry-save
//             mpadder. Option: MONT_SEQ_ZERO_SKIP_EN skips zero B-bit adds.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mont_seq_ctrl
   import mont_seq_ctrl_pkg::*;
#(
   parameter int N_BITS   = N_BITS_DEF,
   parameter int N_CHUNKS = CHUNK_LAST + 1,
   parameter int MAX_SUB  = 3
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       start,
   input  logic       b_bit,
   output logic       b_next,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic       add_clear_n,
   output logic       add_enable_c,
   output logic       add_shift,
   output logic       add_subtract,
   output logic       add_enable_carry,
   output logic [3:0] add_phase,
   output logic [1:0] add_sel,
   input  logic       add_c_zero,
   input  logic       add_sub_done
);

   localparam int ITER_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam int NSUB_W = (MAX_SUB > 1) ? $clog2(MAX_SUB) : 1;

   state_t              r_state;
   state_t              w_eff;
   state_t              w_next;
   logic [ITER_W-1:0]   r_iter;
   logic [NSUB_W-1:0]   r_nsub;
   logic                w_last;
   logic                w_phase_en;
   logic                w_set_error;
   logic                w_nsub_inc;

   // A zero B bit leaves the pair untouched, so the skip build treats the
   // ADD_B cycle as ADD_M directly.
   always_comb begin
      w_eff = r_state;
`ifdef MONT_SEQ_ZERO_SKIP_EN
      if (r_state == S_ADD_B && !b_bit) begin
         w_eff = S_ADD_M;
      end
`endif
   end

   assign w_phase_en = (r_state == S_RES) || (r_state == S_SUB);

   mont_phase_cnt #(
      .N_CHUNKS (N_CHUNKS),
      .PHASE_W  (4)
   ) u_phase_cnt (
      .clk    (clk),
      .resetn (resetn),
      .en     (w_phase_en),
      .phase  (add_phase),
      .last   (w_last)
   );

   always_comb begin
      w_next      = w_eff;
      w_set_error = 1'b0;
      w_nsub_inc  = 1'b0;
      case (w_eff)
         S_IDLE:  if (start) w_next = S_INIT;
         S_INIT:  w_next = S_ADD_B;
         S_ADD_B: w_next = S_ADD_M;
         S_ADD_M: w_next = S_SHIFT;
         S_SHIFT: w_next = (r_iter == ITER_W'(N_BITS - 1)) ? S_RES : S_ADD_B;
         S_RES:   if (w_last) w_next = S_SUB;
         S_SUB: begin
            if (w_last) begin
               if (add_sub_done) begin
                  w_next = S_DONE;
               end else if (r_nsub == NSUB_W'(MAX_SUB - 1)) begin
                  w_next      = S_DONE;
                  w_set_error = 1'b1;
               end else begin
                  w_nsub_inc = 1'b1;
               end
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // These two follow b_bit and add_c_zero within the same cycle; the
   // adder pair they depend on is only valid once that cycle has begun.
   always_comb begin
      add_sel      = SEL_ZERO;
      add_enable_c = 1'b0;
      case (w_eff)
         S_ADD_B: begin
            add_enable_c = 1'b1;
            add_sel      = b_bit ? SEL_A : SEL_ZERO;
         end
         S_ADD_M: begin
            if (add_c_zero) begin
               add_enable_c = 1'b1;
               add_sel      = SEL_M;
            end
         end
         S_SUB:   add_sel = SEL_NEGM;
         default: add_sel = SEL_ZERO;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state          <= S_IDLE;
         r_iter           <= '0;
         r_nsub           <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         b_next           <= 1'b0;
         add_clear_n      <= 1'b1;
         add_shift        <= 1'b0;
         add_subtract     <= 1'b0;
         add_enable_carry <= 1'b0;
      end else begin
         r_state <= w_next;

         if (r_state == S_INIT) begin
            r_iter <= '0;
            r_nsub <= '0;
         end else begin
            if (w_eff == S_SHIFT) r_iter <= r_iter + ITER_W'(1);
            if (w_nsub_inc)       r_nsub <= r_nsub + NSUB_W'(1);
         end

         if (w_next == S_INIT) begin
            error <= 1'b0;
         end else if (w_set_error) begin
            error <= 1'b1;
         end

         busy             <= (w_next != S_IDLE);
         done             <= (w_next == S_DONE);
         b_next           <= (w_next == S_SHIFT);
         add_shift        <= (w_next == S_SHIFT);
         add_clear_n      <= (w_next != S_INIT);
         add_subtract     <= (w_next == S_SUB);
         add_enable_carry <= (w_next == S_RES) || (w_next == S_SUB);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mont_seq_ctrl.sv
// ============================================================================
//  Module   : tb_mont_seq_ctrl
//  Purpose  : Self-checking bench for mont_seq_ctrl against a cycle schedule
//             derived from the iteration/pass rules.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mont_seq_ctrl;

   localparam int NB = 512;
   localparam int K_INIT = 0, K_B = 1, K_M = 2, K_SH = 3, K_RES = 4, K_SUB = 5, K_DONE = 6;
`ifdef MONT_SEQ_ZERO_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   typedef struct {
      int kind;
      int phase;
      int pass;
      int bitv;
   } slot_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start = 1'b0;
   logic b_bit = 1'b0;
   logic add_c_zero = 1'b0;
   logic add_sub_done = 1'b0;
   logic b_next, busy, done, error;
   logic add_clear_n, add_enable_c, add_shift, add_subtract, add_enable_carry;
   logic [3:0] add_phase;
   logic [1:0] add_sel;
   logic [14:0] obs;

   int    n_checks = 0;
   int    n_fail = 0;
   slot_t sched[$];
   int    it_first[NB];
   bit    b_vec[NB];
   int    b_idx;
   int    bn_cnt;

   always #5 clk = ~clk;

   mont_seq_ctrl dut (
      .clk              (clk),
      .resetn           (resetn),
      .start            (start),
      .b_bit            (b_bit),
      .b_next           (b_next),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .add_clear_n      (add_clear_n),
      .add_enable_c     (add_enable_c),
      .add_shift        (add_shift),
      .add_subtract     (add_subtract),
      .add_enable_carry (add_enable_carry),
      .add_phase        (add_phase),
      .add_sel          (add_sel),
      .add_c_zero       (add_c_zero),
      .add_sub_done     (add_sub_done)
   );

   assign obs = {busy, done, error, b_next, add_clear_n, add_enable_c, add_shift,
                 add_subtract, add_enable_carry, add_phase, add_sel};

   function automatic logic [14:0] mk(input int bsy, input int dn, input int er, input int bn,
                                      input int cln, input int enc, input int sh, input int sb,
                                      input int ecr, input int ph, input int sel);
      return {1'(bsy), 1'(dn), 1'(er), 1'(bn), 1'(cln), 1'(enc), 1'(sh), 1'(sb), 1'(ecr),
              4'(ph), 2'(sel)};
   endfunction

   function automatic logic [14:0] slot_exp(input slot_t s, input logic cz, input bit e);
      case (s.kind)
         K_INIT:  return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         K_B:     return mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, s.bitv);
         K_M:     return mk(1, 0, 0, 0, 1, int'(cz), 0, 0, 0, 0, cz ? 2 : 0);
         K_SH:    return mk(1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
         K_RES:   return mk(1, 0, 0, 0, 1, 0, 0, 0, 1, s.phase, 0);
         K_SUB:   return mk(1, 0, 0, 0, 1, 0, 0, 1, 1, s.phase, 3);
         default: return mk(1, 1, int'(e), 0, 1, 0, 0, 0, 0, 0, 0);
      endcase
   endfunction

   // Expected cycle-by-cycle schedule, starting at the INIT cycle (cycle 1).
   task automatic build_sched(input int p);
      sched.delete();
      sched.push_back('{K_INIT, 0, 0, 0});
      for (int k = 0; k < NB; k++) begin
         it_first[k] = sched.size();
         if (!(SKIP && !b_vec[k])) sched.push_back('{K_B, 0, 0, int'(b_vec[k])});
         sched.push_back('{K_M, 0, 0, 0});
         sched.push_back('{K_SH, 0, 0, 0});
      end
      for (int ph = 0; ph < 5; ph++) sched.push_back('{K_RES, ph, 0, 0});
      for (int s = 0; s < p; s++)
         for (int ph = 0; ph < 5; ph++) sched.push_back('{K_SUB, ph, s, 0});
      sched.push_back('{K_DONE, 0, 0, 0});
   endtask

   // p_done: pass (1..3) that reports completion, 0 = never.
   // b_mode: 0 all zero, 1 all one, 2 random.
   task automatic run_op(input string name, input int p_done, input int b_mode,
                         input int pulse_it, input int abort_it, input int exp_done_const);
      int          p;
      int          done_cyc;
      bit          err_exp;
      bit          bn_seen;
      bit          aborted;
      logic [14:0] exp;
      p        = (p_done == 0) ? 3 : p_done;
      err_exp  = (p_done == 0);
      done_cyc = 0;
      aborted  = 1'b0;
      for (int k = 0; k < NB; k++)
         b_vec[k] = (b_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(b_mode);
      build_sched(p);

      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      b_idx  = 0;
      bn_cnt = 0;
      for (int i = 0; i < sched.size(); i++) begin
         b_bit      = (b_idx < NB) ? b_vec[b_idx] : 1'b0;
         add_c_zero = 1'($urandom_range(0, 1));
         if (sched[i].kind == K_SUB && sched[i].phase == 4)
            add_sub_done = (sched[i].pass == p_done - 1);
         else
            add_sub_done = 1'($urandom_range(0, 1));
         start = (pulse_it >= 0 && i == it_first[pulse_it]);
         if (abort_it >= 0 && i == it_first[abort_it]) begin
            resetn = 1'b0;
            #1;
            n_checks++;
            if (obs !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
               n_fail++;
               $display("FAIL %s async_abort: got %h want %h", name, obs,
                        mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
            end
            aborted = 1'b1;
            break;
         end
         @(negedge clk);
         exp = slot_exp(sched[i], add_c_zero, err_exp);
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", name, i + 1, obs, exp);
         end
         if (done === 1'b1 && done_cyc == 0) done_cyc = i + 1;
         bn_seen = (b_next === 1'b1);
         @(posedge clk);
         #1;
         if (bn_seen) begin
            b_idx++;
            bn_cnt++;
         end
      end
      start = 1'b0;

      if (aborted) begin
         @(negedge clk);
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL %s held_in_reset: got %h want %h", name, obs,
                     mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
         end
         @(negedge clk);
         resetn = 1'b1;
         @(negedge clk);
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL %s idle_after_abort: got %h want %h", name, obs,
                     mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
         end
      end else begin
         @(negedge clk);
         n_checks++;
         if (obs !== mk(0, 0, int'(err_exp), 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL %s idle_after_done: got %h want %h", name, obs,
                     mk(0, 0, int'(err_exp), 0, 1, 0, 0, 0, 0, 0, 0));
         end
         n_checks++;
         if (bn_cnt != NB) begin
            n_fail++;
            $display("FAIL %s b_next_count: got %0d want %0d", name, bn_cnt, NB);
         end
         n_checks++;
         if (done_cyc != sched.size()) begin
            n_fail++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, sched.size());
         end
         if (exp_done_const != 0) begin
            n_checks++;
            if (done_cyc != exp_done_const) begin
               n_fail++;
               $display("FAIL %s done_cycle_abs: got %0d want %0d", name, done_cyc, exp_done_const);
            end
         end
      end
   endtask

   task automatic test_reset();
      resetn       = 1'b0;
      start        = 1'b1;
      b_bit        = 1'b1;
      add_c_zero   = 1'b1;
      add_sub_done = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_hold: got %h want %h", obs, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
         end
      end
      start  = 1'b0;
      resetn = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (obs !== mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h want %h", obs, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
         end
      end
   endtask

   task automatic test_full_ones();
      run_op("full_ones", 1, 1, -1, -1, 1548);
   endtask

   task automatic test_zero_bits();
      run_op("zero_bits", 1, 0, -1, -1, SKIP ? 1036 : 1548);
   endtask

   task automatic test_random_ops();
      run_op("random_p2", 2, 2, -1, -1, 0);
      run_op("random_p3", 3, 2, -1, -1, 0);
   endtask

   task automatic test_sub_limit();
      run_op("sub_limit", 0, 2, -1, -1, 0);
      run_op("after_limit", 1, 2, -1, -1, 0);
   endtask

   task automatic test_interference();
      run_op("interference", 1, 2, 100, 200, 0);
      run_op("after_abort", 2, 2, -1, -1, 0);
   endtask

   initial begin
      test_reset();
      test_full_ones();
      test_zero_bits();
      test_random_ops();
      test_sub_limit();
      test_interference();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
